pc_sequencer: RTL and testbench
===============================

# pc_sequencer

Multi-cycle instruction sequencer that owns the program counter and drives the fetch / decode / execute / update cycle of the processor. It fetches a word from instruction memory, requests register operands, resolves the six conditional branches (beq, bne, bgt, bgte, ble, bleq) against the two register operands, and either loads the branch target or increments the PC. It sits between instruction memory, the register file and the branch/ALU datapath, and is the only writer of the PC.

## Interface
- PC_W, 9, PC and branch-target width
- HALT_OP, 6'd63, opcode that stops the sequencer
- TIMEOUT, 16, fetch-wait limit in cycles (used only with the macro below)

- clk  in  1  system clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- start  in  1  begin execution from PC 0; sampled only in IDLE
- inst_data  in  32  instruction memory read data
- inst_valid  in  1  inst_data valid; sampled only in FETCH
- reg_1, reg_2  in  32  register-file operands; sampled only in EXEC
- pc  out  PC_W  current program counter
- inst_reg  out  32  latched current instruction
- imem_rd  out  1  instruction-memory read request
- rf_rd  out  1  register-file read strobe
- rf_wr  out  1  register-file write strobe
- branch_taken  out  1  one-cycle pulse when a branch loads its target
- busy  out  1  high in every state except IDLE and HALT
- halted  out  1  high in HALT
- fetch_err  out  1  sticky fetch-timeout flag

## Operation
- States: IDLE, FETCH, DECODE, EXEC, UPDATE, HALT.
- IDLE: pc held at 0; start=1 -> FETCH.
- FETCH: imem_rd=1; inst_valid=1 -> inst_reg <= inst_data, -> DECODE; otherwise remain.
- DECODE: rf_rd=1 for one cycle; opcode inst_reg[31:26]==HALT_OP -> HALT, else -> EXEC.
- EXEC: opcodes 15..20 evaluate taken = beq(==), bne(!=), bgt(>), bgte(>=), ble(<), bleq(<=) on reg_1 vs reg_2, unsigned 32-bit; result registered. Opcodes 1..14: rf_wr=1 this cycle. Opcode 0 and 21..62: no strobe (NOP).
- UPDATE: taken -> pc <= inst_reg[PC_W-1:0] (bits above PC_W of the 16-bit target field discarded), branch_taken=1; else pc <= pc+1 modulo 2^PC_W (511 -> 0). -> FETCH.
- HALT: terminal; start ignored; leaves only via rst.
- start while busy or halted: ignored.

## Timing
- Reset values: pc=0, inst_reg=0, all strobes 0, busy=0, halted=0, fetch_err=0, state IDLE.
- rst asserted mid-instruction: immediate return to reset values; no strobe completes.
- start in IDLE at cycle n: FETCH at n+1 (imem_rd high).
- inst_valid in first FETCH cycle: FETCH, DECODE, EXEC, UPDATE = 4 cycles per instruction; each extra wait cycle adds one.
- pc updates on the UPDATE->FETCH edge; new pc visible in the following FETCH cycle.
- rf_rd, rf_wr, branch_taken: exactly one cycle wide, combinational from registered state.

## Configuration
- PC_SEQ_FETCH_TIMEOUT_EN defined: wait counter runs in FETCH, cleared on entering FETCH; TIMEOUT consecutive cycles without inst_valid -> fetch_err=1 (sticky until rst), state -> HALT.
- Undefined: no counter; FETCH waits indefinitely; fetch_err tied 0.

## Test plan
- Reset then start, memory returns opcode 1 at PC 0 with immediate inst_valid -> rf_wr pulse in cycle 3 after start, pc=1 four cycles after first FETCH.
- beq (op 15), reg_1=reg_2=5, target 16'h0040 -> branch_taken pulse, pc=9'h040; repeat with reg_2=6 -> pc=previous+1, no pulse.
- bgt with reg_1=32'h8000_0000, reg_2=1 -> taken (unsigned); ble same operands -> not taken.
- pc=511 executing NOP -> pc wraps to 0; branch target 16'h0305 -> pc=9'h105.
- HALT_OP fetched -> halted=1, busy=0, start pulses ignored; rst asserted during EXEC of a later run -> all outputs at reset values same cycle.
- With PC_SEQ_FETCH_TIMEOUT_EN, inst_valid held low 16 cycles -> fetch_err=1, halted=1; inst_valid on cycle 15 -> normal DECODE, fetch_err=0.

Source files
------------

// File: rtl/pc_sequencer.sv
// Multi-cycle fetch/decode/execute/update sequencer that owns the program counter.
// Optional fetch-wait timeout is enabled with `define PC_SEQ_FETCH_TIMEOUT_EN.
module pc_sequencer #(
    parameter int          PC_W    = 9,
    parameter logic [5:0]  HALT_OP = 6'd63,
    parameter int          TIMEOUT = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [31:0]     inst_data,
    input  logic            inst_valid,
    input  logic [31:0]     reg_1,
    input  logic [31:0]     reg_2,
    output logic [PC_W-1:0] pc,
    output logic [31:0]     inst_reg,
    output logic            imem_rd,
    output logic            rf_rd,
    output logic            rf_wr,
    output logic            branch_taken,
    output logic            busy,
    output logic            halted,
    output logic            fetch_err
);

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        DECODE,
        EXEC,
        UPDATE,
        HALT
    } state_t;

    state_t     state, state_nx;
    logic       taken_q;
    logic       taken;
    logic       timeout_hit;
    logic [5:0] op;

    // Elaboration-time sanity checks on the configuration.
    if (TIMEOUT < 1) begin : g_timeout_check
        $error("pc_sequencer: TIMEOUT must be at least 1");
    end
    if (PC_W < 1 || PC_W > 16) begin : g_pcw_check
        $error("pc_sequencer: PC_W must be in 1..16");
    end

    assign op = inst_reg[31:26];

`ifdef PC_SEQ_FETCH_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT - 1);

    logic [CNT_W-1:0] wait_cnt;
    logic             err_q;

    assign timeout_hit = (state == FETCH) && !inst_valid && (wait_cnt == CNT_MAX);
    assign fetch_err   = err_q;

    // Counter is zero whenever FETCH is entered, so it only counts consecutive waits.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wait_cnt <= '0;
            err_q    <= 1'b0;
        end else begin
            if (state == FETCH && !inst_valid && !timeout_hit)
                wait_cnt <= wait_cnt + 1'b1;
            else
                wait_cnt <= '0;
            if (timeout_hit)
                err_q <= 1'b1;
        end
    end
`else
    assign timeout_hit = 1'b0;
    assign fetch_err   = 1'b0;
`endif

    always_comb begin
        taken = 1'b0;
        unique case (op)
            6'd15:   taken = (reg_1 == reg_2);
            6'd16:   taken = (reg_1 != reg_2);
            6'd17:   taken = (reg_1 >  reg_2);
            6'd18:   taken = (reg_1 >= reg_2);
            6'd19:   taken = (reg_1 <  reg_2);
            6'd20:   taken = (reg_1 <= reg_2);
            default: taken = 1'b0;
        endcase
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    if (start) state_nx = FETCH;
            FETCH: begin
                if (inst_valid)
                    state_nx = DECODE;
                else if (timeout_hit)
                    state_nx = HALT;
            end
            DECODE:  state_nx = (op == HALT_OP) ? HALT : EXEC;
            EXEC:    state_nx = UPDATE;
            UPDATE:  state_nx = FETCH;
            HALT:    state_nx = HALT;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            pc       <= '0;
            inst_reg <= '0;
            taken_q  <= 1'b0;
        end else begin
            state <= state_nx;
            if (state == FETCH && inst_valid)
                inst_reg <= inst_data;
            if (state == EXEC)
                taken_q <= taken;
            if (state == IDLE)
                pc <= '0;
            else if (state == UPDATE)
                pc <= taken_q ? inst_reg[PC_W-1:0] : pc + 1'b1;
        end
    end

    assign imem_rd      = (state == FETCH);
    assign rf_rd        = (state == DECODE);
    assign rf_wr        = (state == EXEC) && (op >= 6'd1) && (op <= 6'd14);
    assign branch_taken = (state == UPDATE) && taken_q;
    assign busy         = (state != IDLE) && (state != HALT);
    assign halted       = (state == HALT);

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed, table-driven bench for pc_sequencer; checks strobes, pc sequence,
// halt/reset behaviour and, when PC_SEQ_FETCH_TIMEOUT_EN is defined, the fetch timeout.
module tb_pc_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [31:0] inst_data;
    logic        inst_valid;
    logic [31:0] reg_1, reg_2;
    logic [8:0]  pc;
    logic [31:0] inst_reg;
    logic        imem_rd, rf_rd, rf_wr, branch_taken, busy, halted, fetch_err;

    int n_checks = 0;
    int n_fail   = 0;

    pc_sequencer #(.PC_W(9), .HALT_OP(6'd63), .TIMEOUT(16)) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .inst_data    (inst_data),
        .inst_valid   (inst_valid),
        .reg_1        (reg_1),
        .reg_2        (reg_2),
        .pc           (pc),
        .inst_reg     (inst_reg),
        .imem_rd      (imem_rd),
        .rf_rd        (rf_rd),
        .rf_wr        (rf_wr),
        .branch_taken (branch_taken),
        .busy         (busy),
        .halted       (halted),
        .fetch_err    (fetch_err)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [5:0]  op;
        logic [15:0] tgt;
        logic [31:0] r1;
        logic [31:0] r2;
        int          waits;
        logic        exp_wr;
        logic        exp_br;
        logic [8:0]  exp_pc;
    } vec_t;

    vec_t vecs[16];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, " pc"}, 32'(pc), 32'h0);
        chk({tag, " inst_reg"}, inst_reg, 32'h0);
        chk({tag, " strobes"}, {28'h0, imem_rd, rf_rd, rf_wr, branch_taken}, 32'h0);
        chk({tag, " busy/halted/err"}, {29'h0, busy, halted, fetch_err}, 32'h0);
    endtask

    // Starts at a negedge in FETCH; ends at the negedge after UPDATE.
    task automatic run_instr(input int idx, input logic [8:0] cur_pc, input vec_t v);
        logic [31:0] word;
        word = {v.op, 10'h0, v.tgt};
        chk($sformatf("v%0d fetch pc", idx), 32'(pc), 32'(cur_pc));
        inst_valid = 1'b0;
        for (int w = 0; w < v.waits; w++) begin
            chk($sformatf("v%0d wait imem_rd", idx), 32'(imem_rd), 32'h1);
            @(negedge clk);
        end
        chk($sformatf("v%0d imem_rd", idx), 32'(imem_rd), 32'h1);
        inst_data  = word;
        inst_valid = 1'b1;
        @(negedge clk);
        inst_valid = 1'b0;
        inst_data  = 32'hDEAD_BEEF;
        chk($sformatf("v%0d decode rf_rd", idx), 32'(rf_rd), 32'h1);
        chk($sformatf("v%0d inst_reg", idx), inst_reg, word);
        reg_1 = v.r1;
        reg_2 = v.r2;
        @(negedge clk);
        chk($sformatf("v%0d exec rf_wr", idx), 32'(rf_wr), 32'(v.exp_wr));
        @(negedge clk);
        reg_1 = 32'h0;
        reg_2 = 32'hFFFF_FFFF;
        chk($sformatf("v%0d update branch_taken", idx), 32'(branch_taken), 32'(v.exp_br));
        chk($sformatf("v%0d update rf_wr", idx), 32'(rf_wr), 32'h0);
        @(negedge clk);
        chk($sformatf("v%0d branch_taken width", idx), 32'(branch_taken), 32'h0);
        chk($sformatf("v%0d next pc", idx), 32'(pc), 32'(v.exp_pc));
    endtask

    initial begin
        logic [8:0] cur_pc;

        vecs[0]  = '{6'd1,  16'h0000, 32'd0,         32'd0, 0, 1'b1, 1'b0, 9'h001};
        vecs[1]  = '{6'd15, 16'h0040, 32'd5,         32'd5, 0, 1'b0, 1'b1, 9'h040};
        vecs[2]  = '{6'd15, 16'h0040, 32'd5,         32'd6, 0, 1'b0, 1'b0, 9'h041};
        vecs[3]  = '{6'd16, 16'h0010, 32'd5,         32'd6, 1, 1'b0, 1'b1, 9'h010};
        vecs[4]  = '{6'd17, 16'h0020, 32'h8000_0000, 32'd1, 0, 1'b0, 1'b1, 9'h020};
        vecs[5]  = '{6'd19, 16'h0030, 32'h8000_0000, 32'd1, 0, 1'b0, 1'b0, 9'h021};
        vecs[6]  = '{6'd18, 16'h01FF, 32'd7,         32'd7, 0, 1'b0, 1'b1, 9'h1FF};
        vecs[7]  = '{6'd0,  16'h0000, 32'd3,         32'd3, 2, 1'b0, 1'b0, 9'h000};
        vecs[8]  = '{6'd20, 16'h0100, 32'd3,         32'd2, 0, 1'b0, 1'b0, 9'h001};
        vecs[9]  = '{6'd20, 16'h0305, 32'd2,         32'd3, 0, 1'b0, 1'b1, 9'h105};
        vecs[10] = '{6'd14, 16'h0000, 32'd9,         32'd9, 0, 1'b1, 1'b0, 9'h106};
        vecs[11] = '{6'd21, 16'h0000, 32'd9,         32'd9, 0, 1'b0, 1'b0, 9'h107};
        vecs[12] = '{6'd18, 16'h0000, 32'd1,         32'd2, 0, 1'b0, 1'b0, 9'h108};
        vecs[13] = '{6'd17, 16'h0000, 32'd5,         32'd5, 0, 1'b0, 1'b0, 9'h109};
        vecs[14] = '{6'd19, 16'h0002, 32'd1,         32'd2, 0, 1'b0, 1'b1, 9'h002};
        vecs[15] = '{6'd16, 16'h0000, 32'd4,         32'd4, 0, 1'b0, 1'b0, 9'h003};

        rst        = 1'b1;
        start      = 1'b0;
        inst_data  = 32'h0;
        inst_valid = 1'b0;
        reg_1      = 32'h0;
        reg_2      = 32'h0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        chk_reset_outputs("reset");
        @(negedge clk);
        chk("idle holds", {30'h0, busy, imem_rd}, 32'h0);

        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("start -> fetch", {30'h0, busy, imem_rd}, 32'h3);

        cur_pc = 9'h000;
        for (int i = 0; i < 16; i++) begin
            run_instr(i, cur_pc, vecs[i]);
            cur_pc = vecs[i].exp_pc;
        end

        // HALT opcode: terminal, start ignored.
        inst_data  = {6'd63, 26'h0};
        inst_valid = 1'b1;
        @(negedge clk);
        inst_valid = 1'b0;
        chk("halt decode rf_rd", 32'(rf_rd), 32'h1);
        @(negedge clk);
        chk("halted", {30'h0, halted, busy}, 32'h2);
        start = 1'b1;
        repeat (3) @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        chk("halt ignores start", {29'h0, halted, busy, imem_rd}, 32'h4);
        chk("halt pc frozen", 32'(pc), 32'h003);

        // Async reset during EXEC of a later run.
        rst = 1'b1;
        #1;
        rst = 1'b0;
        chk_reset_outputs("reset after halt");
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        run_instr(16, 9'h000, vecs[0]);
        inst_data  = {6'd2, 26'h0};
        inst_valid = 1'b1;
        @(negedge clk);
        inst_valid = 1'b0;
        @(negedge clk);
        chk("pre-reset exec rf_wr", 32'(rf_wr), 32'h1);
        rst = 1'b1;
        #1;
        chk_reset_outputs("reset in exec");
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("post-reset idle", {30'h0, busy, halted}, 32'h0);

        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
`ifdef PC_SEQ_FETCH_TIMEOUT_EN
        // Valid arrives on the last permitted wait cycle: normal decode.
        for (int w = 0; w < 15; w++) @(negedge clk);
        chk("late valid still fetching", 32'(imem_rd), 32'h1);
        inst_data  = {6'd0, 26'h0};
        inst_valid = 1'b1;
        @(negedge clk);
        inst_valid = 1'b0;
        chk("late valid decode", {30'h0, rf_rd, fetch_err}, 32'h2);
        repeat (3) @(negedge clk);
        chk("after late valid pc", 32'(pc), 32'h001);
        for (int w = 0; w < 16; w++) @(negedge clk);
        chk("timeout fetch_err/halted", {30'h0, fetch_err, halted}, 32'h3);
        chk("timeout busy", 32'(busy), 32'h0);
        repeat (2) @(negedge clk);
        chk("fetch_err sticky", 32'(fetch_err), 32'h1);
`else
        for (int w = 0; w < 20; w++) @(negedge clk);
        chk("no timeout still fetching", {29'h0, imem_rd, halted, fetch_err}, 32'h4);
        inst_data  = {6'd0, 26'h0};
        inst_valid = 1'b1;
        @(negedge clk);
        inst_valid = 1'b0;
        chk("long wait decode", 32'(rf_rd), 32'h1);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
